// File: rtl/button_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// button_cmd_ctrl
//
// Turns two debounced push-button levels into user commands. A press on the
// select button steps a wrapping selection value; a press on the go button
// latches that selection and starts a req/ack handshake with the serial-bus
// controller, then follows the transaction until the controller reports done.
// An unacknowledged request is abandoned after ACK_TIMEOUT cycles and a
// sticky error flag is raised until the next go press.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rstN         asynchronous active-low reset
//   sel_btn_in   debounced select button level
//   go_btn_in    debounced go button level
//   start_ack    controller accepts the pending request
//   busy_done    controller finished the transaction (one-cycle pulse)
//   sel_value    current selection, 0..NUM_SEL-1
//   cmd_value    selection captured at the go press
//   start_req    start request to the controller
//   busy         transaction in progress
//   timeout_err  sticky: last request was not acknowledged in time
// ---------------------------------------------------------------------------
module button_cmd_ctrl #(
    parameter int   NUM_SEL     = 4,
    parameter int   ACK_TIMEOUT = 1000,
    parameter logic PRESS_LEVEL = 1'b0,
    localparam int  SEL_WIDTH   = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 sel_btn_in,
    input  logic                 go_btn_in,
    input  logic                 start_ack,
    input  logic                 busy_done,
    output logic [SEL_WIDTH-1:0] sel_value,
    output logic [SEL_WIDTH-1:0] cmd_value,
    output logic                 start_req,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int CNT_WIDTH = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ACK_TIMEOUT - 1);
    localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(NUM_SEL - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic sel_s1;
    logic sel_s2;
    logic go_s1;
    logic go_s2;
    logic sel_press;
    logic go_press;

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic [SEL_WIDTH-1:0] sel_nxt;
    logic [SEL_WIDTH-1:0] cmd_nxt;
    logic                 req_nxt;
    logic                 busy_nxt;
    logic                 err_nxt;

    // Sample flops reset to the pressed level so that a button already held
    // when reset is released looks "still pressed" and produces no edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sel_s1 <= PRESS_LEVEL;
            sel_s2 <= PRESS_LEVEL;
            go_s1  <= PRESS_LEVEL;
            go_s2  <= PRESS_LEVEL;
        end else begin
            sel_s1 <= sel_btn_in;
            sel_s2 <= sel_s1;
            go_s1  <= go_btn_in;
            go_s2  <= go_s1;
        end
    end

    // A press is the cycle in which the newest sample is pressed and the
    // previous one was not; holding the button gives exactly one press.
    assign sel_press = (sel_s1 == PRESS_LEVEL) && (sel_s2 != PRESS_LEVEL);
    assign go_press  = (go_s1 == PRESS_LEVEL) && (go_s2 != PRESS_LEVEL);

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack arriving on the timeout cycle still wins.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go_press) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (start_ack) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (busy_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output/datapath next values. Presses outside IDLE fall through the
    // default assignments and are therefore dropped; go beats sel in IDLE so
    // the command captures the selection before any increment.
    always_comb begin
        sel_nxt  = sel_value;
        cmd_nxt  = cmd_value;
        req_nxt  = start_req;
        busy_nxt = busy;
        err_nxt  = timeout_err;
        cnt_nxt  = cnt;
        case (state)
            IDLE: begin
                if (go_press) begin
                    cmd_nxt = sel_value;
                    req_nxt = 1'b1;
                    err_nxt = 1'b0;
                    cnt_nxt = '0;
                end else if (sel_press) begin
                    sel_nxt = (sel_value == SEL_LAST) ? '0 : sel_value + SEL_WIDTH'(1);
                end
            end
            REQ: begin
                cnt_nxt = cnt + CNT_WIDTH'(1);
                if (start_ack) begin
                    req_nxt  = 1'b0;
                    busy_nxt = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    req_nxt = 1'b0;
                    err_nxt = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (busy_done) begin
                    busy_nxt = 1'b0;
                end
            end
            default: begin
                req_nxt  = 1'b0;
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs and timeout counter
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sel_value   <= '0;
            cmd_value   <= '0;
            start_req   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= '0;
        end else begin
            sel_value   <= sel_nxt;
            cmd_value   <= cmd_nxt;
            start_req   <= req_nxt;
            busy        <= busy_nxt;
            timeout_err <= err_nxt;
            cnt         <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_button_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_button_cmd_ctrl
//
// Directed bench for button_cmd_ctrl with NUM_SEL=4 and ACK_TIMEOUT=8.
// Inputs change on the falling clock edge and outputs are sampled there too,
// so a button change driven at one falling edge shows its effect after the
// second following rising edge.
// ---------------------------------------------------------------------------
module tb_button_cmd_ctrl;

    logic       clk;
    logic       rstN;
    logic       sel_btn_in;
    logic       go_btn_in;
    logic       start_ack;
    logic       busy_done;
    logic [1:0] sel_value;
    logic [1:0] cmd_value;
    logic       start_req;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    button_cmd_ctrl #(
        .NUM_SEL    (4),
        .ACK_TIMEOUT(8),
        .PRESS_LEVEL(1'b0)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .sel_btn_in (sel_btn_in),
        .go_btn_in  (go_btn_in),
        .start_ack  (start_ack),
        .busy_done  (busy_done),
        .sel_value  (sel_value),
        .cmd_value  (cmd_value),
        .start_req  (start_req),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    // 50 MHz clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Buttons held pressed through reset must not register as presses.
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({sel_value, cmd_value, start_req, busy, timeout_err} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: got %b expected 0000000",
                     {sel_value, cmd_value, start_req, busy, timeout_err});
        end
        rstN = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (sel_value !== 2'd0 || start_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_through_reset: sel=%0d req=%b expected sel=0 req=0",
                     sel_value, start_req);
        end
        sel_btn_in = 1'b1;
        go_btn_in  = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (sel_value !== 2'd0 || start_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_no_action: sel=%0d req=%b busy=%b expected 0 0 0",
                     sel_value, start_req, busy);
        end
    endtask

    // Five presses walk the selection 1,2,3,0,1 with a two-edge latency.
    task automatic test_sel_step();
        logic [1:0] expect_seq [5];
        logic [1:0] prev;
        expect_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        prev = 2'd0;
        for (int i = 0; i < 5; i++) begin
            sel_btn_in = 1'b0;
            @(negedge clk);
            checks++;
            if (sel_value !== prev) begin
                errors++;
                $display("[TB] FAIL sel_early_%0d: got %0d expected %0d", i, sel_value, prev);
            end
            @(negedge clk);
            checks++;
            if (sel_value !== expect_seq[i]) begin
                errors++;
                $display("[TB] FAIL sel_step_%0d: got %0d expected %0d", i, sel_value, expect_seq[i]);
            end
            repeat (8) @(negedge clk);
            checks++;
            if (sel_value !== expect_seq[i]) begin
                errors++;
                $display("[TB] FAIL sel_hold_%0d: got %0d expected %0d", i, sel_value, expect_seq[i]);
            end
            sel_btn_in = 1'b1;
            repeat (10) @(negedge clk);
            prev = expect_seq[i];
        end
    endtask

    // Selection 2, go, ack after four request cycles, done twenty cycles later.
    task automatic test_handshake();
        sel_btn_in = 1'b0;
        repeat (2) @(negedge clk);
        sel_btn_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sel_value !== 2'd2) begin
            errors++;
            $display("[TB] FAIL hs_sel_setup: got %0d expected 2", sel_value);
        end
        go_btn_in = 1'b0;
        @(negedge clk);
        checks++;
        if (start_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hs_req_early: got %b expected 0", start_req);
        end
        @(negedge clk);
        checks++;
        if (start_req !== 1'b1 || cmd_value !== 2'd2 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hs_req_rise: req=%b cmd=%0d busy=%b expected 1 2 0",
                     start_req, cmd_value, busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (start_req !== 1'b1) begin
                errors++;
                $display("[TB] FAIL hs_req_held_%0d: got %b expected 1", i, start_req);
            end
        end
        start_ack = 1'b1;
        @(negedge clk);
        start_ack = 1'b0;
        go_btn_in = 1'b1;
        checks++;
        if (start_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hs_ack: req=%b busy=%b expected 0 1", start_req, busy);
        end
        repeat (19) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || cmd_value !== 2'd2 || timeout_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hs_busy_hold: busy=%b cmd=%0d err=%b expected 1 2 0",
                     busy, cmd_value, timeout_err);
        end
        busy_done = 1'b1;
        @(negedge clk);
        busy_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || start_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hs_done: busy=%b req=%b expected 0 0", busy, start_req);
        end
    endtask

    // Unacknowledged request lasts exactly ACK_TIMEOUT cycles; the next go
    // clears the error, and an ack on the final allowed cycle still wins.
    task automatic test_timeout();
        int n;
        go_btn_in = 1'b0;
        repeat (2) @(negedge clk);
        n = 0;
        while (start_req === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("[TB] FAIL to_req_cycles: got %0d expected 8", n);
        end
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_err_set: err=%b busy=%b expected 1 0", timeout_err, busy);
        end
        go_btn_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || start_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_err_sticky: err=%b req=%b expected 1 0", timeout_err, start_req);
        end
        go_btn_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0 || start_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_err_clear: err=%b req=%b expected 0 1", timeout_err, start_req);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (start_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_last_cycle_req: got %b expected 1", start_req);
        end
        start_ack = 1'b1;
        @(negedge clk);
        start_ack = 1'b0;
        go_btn_in = 1'b1;
        checks++;
        if (busy !== 1'b1 || start_req !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_ack_wins: busy=%b req=%b err=%b expected 1 0 0",
                     busy, start_req, timeout_err);
        end
        busy_done = 1'b1;
        @(negedge clk);
        busy_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Same-cycle sel and go: go wins with the pre-increment value; a sel
    // press while busy is discarded.
    task automatic test_simultaneous();
        sel_btn_in = 1'b0;
        repeat (2) @(negedge clk);
        sel_btn_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sel_value !== 2'd3) begin
            errors++;
            $display("[TB] FAIL sim_sel_setup: got %0d expected 3", sel_value);
        end
        sel_btn_in = 1'b0;
        go_btn_in  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_value !== 2'd3 || sel_value !== 2'd3 || start_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sim_go_wins: cmd=%0d sel=%0d req=%b expected 3 3 1",
                     cmd_value, sel_value, start_req);
        end
        start_ack = 1'b1;
        @(negedge clk);
        start_ack  = 1'b0;
        sel_btn_in = 1'b1;
        go_btn_in  = 1'b1;
        repeat (3) @(negedge clk);
        sel_btn_in = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (sel_value !== 2'd3 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sim_sel_in_busy: sel=%0d busy=%b expected 3 1", sel_value, busy);
        end
        busy_done = 1'b1;
        @(negedge clk);
        busy_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sel_value !== 2'd3 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sim_not_queued: sel=%0d busy=%b expected 3 0", sel_value, busy);
        end
        sel_btn_in = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Reset during WAIT_DONE clears outputs without waiting for a clock;
    // a late busy_done is ignored.
    task automatic test_reset_mid_op();
        go_btn_in = 1'b0;
        repeat (2) @(negedge clk);
        start_ack = 1'b1;
        @(negedge clk);
        start_ack = 1'b0;
        go_btn_in = 1'b1;
        checks++;
        if (busy !== 1'b1 || cmd_value !== 2'd3) begin
            errors++;
            $display("[TB] FAIL rst_setup: busy=%b cmd=%0d expected 1 3", busy, cmd_value);
        end
        @(posedge clk);
        #3 rstN = 1'b0;
        #1;
        checks++;
        if ({sel_value, cmd_value, start_req, busy, timeout_err} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL rst_async: got %b expected 0000000",
                     {sel_value, cmd_value, start_req, busy, timeout_err});
        end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        busy_done = 1'b1;
        @(negedge clk);
        busy_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || start_req !== 1'b0 || sel_value !== 2'd0) begin
            errors++;
            $display("[TB] FAIL rst_done_ignored: busy=%b req=%b sel=%0d expected 0 0 0",
                     busy, start_req, sel_value);
        end
    endtask

    initial begin
        rstN       = 1'b0;
        sel_btn_in = 1'b0;
        go_btn_in  = 1'b0;
        start_ack  = 1'b0;
        busy_done  = 1'b0;
        test_reset();
        test_sel_step();
        test_handshake();
        test_timeout();
        test_simultaneous();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
